// File: rtl/esc_sequencer.sv
`default_nettype none
// =====================================================================
// Module   : esc_sequencer
// Brief    : ESC arm/disarm sequencer with command-loss failsafe; the
//            optional ms slew limiter is enabled by ESC_SEQ_SLEW_EN.
// Revision : 1.0  initial release
// =====================================================================
module esc_sequencer #(
   parameter int VAL_BITS   = 10,
   parameter int MAX_VAL    = 1000,
   parameter int ARM_MS     = 3000,
   parameter int TIMEOUT_MS = 100,
   parameter int RAMP_STEP  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tmr_1Mhz,
   input  logic                arm_req,
   input  logic                disarm,
   input  logic [VAL_BITS-1:0] cmd_val,
   input  logic                cmd_vld,
   output logic                cmd_rdy,
   output logic [VAL_BITS-1:0] esc_val,
   output logic                armed,
   output logic                fault
);
   localparam int c_arm_w = $clog2(ARM_MS + 1);
   localparam int c_to_w  = $clog2(TIMEOUT_MS + 1);
   localparam logic [9:0]          c_pre_last = 10'd999;
   localparam logic [c_arm_w-1:0]  c_arm_last = c_arm_w'(ARM_MS - 1);
   localparam logic [c_to_w-1:0]   c_to_last  = c_to_w'(TIMEOUT_MS - 1);
   localparam logic [VAL_BITS-1:0] c_max      = VAL_BITS'(MAX_VAL);
   localparam logic [VAL_BITS-1:0] c_ramp     = VAL_BITS'(RAMP_STEP);

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMING   = 2'd1,
      ARMED    = 2'd2,
      FAILSAFE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [9:0]          pre_q, pre_d;
   logic [c_arm_w-1:0]  arm_cnt_q, arm_cnt_d;
   logic [c_to_w-1:0]   to_cnt_q, to_cnt_d;
   logic [VAL_BITS-1:0] target_q, target_d;
   logic [VAL_BITS-1:0] esc_val_q, esc_val_d;
   logic                cmd_rdy_q, cmd_rdy_d;
   logic                armed_q, armed_d;
   logic                fault_q, fault_d;

   logic                w_tick;
   logic                w_accept;
   logic                w_state_chg;
   logic [VAL_BITS-1:0] w_clamp;
   logic [VAL_BITS-1:0] w_tgt_next;
   logic [VAL_BITS-1:0] w_next_esc;

   assign w_tick     = tmr_1Mhz && (pre_q == c_pre_last);
   // disarm outranks a handshake that happens in the same cycle
   assign w_accept   = cmd_vld && cmd_rdy_q && !disarm;
   assign w_clamp    = (cmd_val > c_max) ? c_max : cmd_val;
   assign w_tgt_next = w_accept ? w_clamp : target_q;

`ifdef ESC_SEQ_SLEW_EN
   logic [VAL_BITS-1:0] w_diff;

   always_comb begin
      w_next_esc = esc_val_q;
      w_diff     = '0;
      if (w_tick) begin
         if (target_q > esc_val_q) begin
            w_diff     = target_q - esc_val_q;
            w_next_esc = esc_val_q + ((w_diff > c_ramp) ? c_ramp : w_diff);
         end else if (target_q < esc_val_q) begin
            w_diff     = esc_val_q - target_q;
            w_next_esc = esc_val_q - ((w_diff > c_ramp) ? c_ramp : w_diff);
         end
      end
   end
`else
   logic w_unused_ramp;

   assign w_unused_ramp = ^c_ramp;
   assign w_next_esc    = w_tgt_next;
`endif

   always_comb begin
      state_d = state_q;
      if (disarm) begin
         state_d = DISARMED;
      end else begin
         case (state_q)
            DISARMED: if (arm_req) state_d = ARMING;
            ARMING:   if (w_tick && (arm_cnt_q == c_arm_last)) state_d = ARMED;
            ARMED:    if (!w_accept && w_tick && (to_cnt_q == c_to_last)) state_d = FAILSAFE;
            FAILSAFE: state_d = FAILSAFE;
            default:  state_d = DISARMED;
         endcase
      end
      w_state_chg = (state_d != state_q);

      pre_d = pre_q;
      if (w_state_chg || w_tick) pre_d = '0;
      else if (tmr_1Mhz)         pre_d = pre_q + 10'd1;

      arm_cnt_d = '0;
      if ((state_q == ARMING) && !w_state_chg)
         arm_cnt_d = w_tick ? arm_cnt_q + c_arm_w'(1) : arm_cnt_q;

      to_cnt_d = '0;
      if ((state_q == ARMED) && !w_state_chg && !w_accept)
         to_cnt_d = w_tick ? to_cnt_q + c_to_w'(1) : to_cnt_q;

      target_d  = '0;
      esc_val_d = '0;
      if (state_d == ARMED) begin
         target_d  = w_tgt_next;
         esc_val_d = w_next_esc;
      end

      cmd_rdy_d = (state_d == ARMED);
      armed_d   = (state_d == ARMED);
      fault_d   = (state_d == FAILSAFE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= DISARMED;
         pre_q     <= '0;
         arm_cnt_q <= '0;
         to_cnt_q  <= '0;
         target_q  <= '0;
         esc_val_q <= '0;
         cmd_rdy_q <= 1'b0;
         armed_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         arm_cnt_q <= arm_cnt_d;
         to_cnt_q  <= to_cnt_d;
         target_q  <= target_d;
         esc_val_q <= esc_val_d;
         cmd_rdy_q <= cmd_rdy_d;
         armed_q   <= armed_d;
         fault_q   <= fault_d;
      end
   end

   assign cmd_rdy = cmd_rdy_q;
   assign esc_val = esc_val_q;
   assign armed   = armed_q;
   assign fault   = fault_q;
endmodule
`default_nettype wire

// File: tb/tb_esc_sequencer.sv
`default_nettype none
// Bench for esc_sequencer: cycle-level behavioural model plus directed literal checks.
module tb_esc_sequencer;
   localparam int VB    = 10;
   localparam int MAXV  = 1000;
   localparam int ARMMS = 2;
   localparam int TOMS  = 3;
   localparam int STEP  = 4;

   logic          clk = 1'b0, rst = 1'b0, tmr = 1'b0;
   logic          arm_req = 1'b0, disarm = 1'b0, cmd_vld = 1'b0;
   logic [VB-1:0] cmd_val = '0;
   logic          cmd_rdy, armed, fault;
   logic [VB-1:0] esc_val;

   int checks = 0;
   int errors = 0;
   int pcnt   = 0;
   int seq[$];

   esc_sequencer #(.VAL_BITS(VB), .MAX_VAL(MAXV), .ARM_MS(ARMMS),
                   .TIMEOUT_MS(TOMS), .RAMP_STEP(STEP)) dut (
      .clk(clk), .rst(rst), .tmr_1Mhz(tmr), .arm_req(arm_req), .disarm(disarm),
      .cmd_val(cmd_val), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .esc_val(esc_val),
      .armed(armed), .fault(fault));

   always #5 clk = ~clk;

   // 1 us strobe: high for one clock every two clocks
   initial forever begin
      @(negedge clk);
      tmr = ~tmr;
   end

   always @(posedge clk) if (tmr) pcnt++;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: 0 disarmed, 1 arming, 2 armed, 3 failsafe
   int m_st, m_us, m_ms, m_idle, m_tgt, m_esc;
   always @(posedge clk or posedge rst) begin
      int nst;
      int tick, acc;
      if (rst) begin
         m_st = 0; m_us = 0; m_ms = 0; m_idle = 0; m_tgt = 0; m_esc = 0;
      end else begin
         tick = (tmr && m_us == 999) ? 1 : 0;
         acc  = (m_st == 2 && cmd_vld && !disarm) ? 1 : 0;
         nst  = m_st;
         if (disarm)                                                 nst = 0;
         else if (m_st == 0 && arm_req)                              nst = 1;
         else if (m_st == 1 && tick == 1 && m_ms + 1 == ARMMS)       nst = 2;
         else if (m_st == 2 && acc == 0 && tick == 1 && m_idle + 1 == TOMS) nst = 3;
         if (nst != m_st)  m_us = 0;
         else if (tmr)     m_us = (tick == 1) ? 0 : m_us + 1;
         m_ms   = (nst == 1 && m_st == 1) ? m_ms + tick : 0;
         m_idle = (nst == 2 && m_st == 2 && acc == 0) ? m_idle + tick : 0;
         if (nst != 2) begin
            m_tgt = 0;
            m_esc = 0;
         end else begin
`ifdef ESC_SEQ_SLEW_EN
            if (tick == 1) begin
               if (m_tgt > m_esc)      m_esc = m_esc + ((m_tgt - m_esc < STEP) ? m_tgt - m_esc : STEP);
               else if (m_tgt < m_esc) m_esc = m_esc - ((m_esc - m_tgt < STEP) ? m_esc - m_tgt : STEP);
            end
            if (acc == 1) m_tgt = (int'(cmd_val) > MAXV) ? MAXV : int'(cmd_val);
`else
            if (acc == 1) m_tgt = (int'(cmd_val) > MAXV) ? MAXV : int'(cmd_val);
            m_esc = m_tgt;
`endif
         end
         m_st = nst;
      end
   end

   // Per-cycle comparison of {cmd_rdy, armed, fault, esc_val} against the model
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         int act, exp;
         act = int'({cmd_rdy, armed, fault, esc_val});
         exp = int'({(m_st == 2), (m_st == 2), (m_st == 3), 10'(m_esc)});
         chk("model_outputs", act, exp);
      end
   end

   task automatic cyc(int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_arm(string tag);
      int p0, n;
      cmd_vld = 1'b1;
      cmd_val = '0;
      while (tmr) cyc(1);
      arm_req = 1'b1;
      p0 = pcnt;
      cyc(1);
      arm_req = 1'b0;
      n = 0;
      while (!armed && n < 10000) begin
         cyc(1);
         n++;
         if (n == 500) begin
            chk({tag, "_rdy_while_arming"}, int'(cmd_rdy), 0);
            chk({tag, "_esc_while_arming"}, int'(esc_val), 0);
         end
      end
      chk({tag, "_pulses_to_armed"}, pcnt - p0, ARMMS * 1000);
   endtask

   task automatic collect(int cnt);
      int prev, n;
      seq.delete();
      prev = int'(esc_val);
      n = 0;
      while (seq.size() < cnt && n < 20000) begin
         cyc(1);
         n++;
         if (int'(esc_val) != prev) begin
            prev = int'(esc_val);
            seq.push_back(prev);
         end
      end
      chk("ramp_step_count", seq.size(), cnt);
   endtask

   initial begin
      int n;
      int up[5];
      int dn[5];
      up = '{4, 8, 12, 16, 20};
      dn = '{18, 14, 10, 6, 5};
      #1 rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(2);
      chk("rst_esc", int'(esc_val), 0);
      chk("rst_armed", int'(armed), 0);
      chk("rst_fault", int'(fault), 0);
      chk("rst_rdy", int'(cmd_rdy), 0);

      do_arm("arm1");
      chk("arm1_rdy", int'(cmd_rdy), 1);

`ifdef ESC_SEQ_SLEW_EN
      cmd_val = 10'd20;
      collect(5);
      foreach (up[i]) chk("ramp_up", (i < seq.size()) ? seq[i] : -1, up[i]);
      cyc(2000);
      chk("ramp_hold_20", int'(esc_val), 20);
      cmd_val = 10'd22;
      collect(1);
      chk("ramp_partial_22", (seq.size() > 0) ? seq[0] : -1, 22);
      cmd_val = 10'd5;
      collect(5);
      foreach (dn[i]) chk("ramp_down", (i < seq.size()) ? seq[i] : -1, dn[i]);
      cmd_val = 10'd1023;
      collect(1);
      chk("ramp_after_clamp", (seq.size() > 0) ? seq[0] : -1, 9);
`else
      cmd_val = 10'd300;
      cyc(1);
      chk("noslew_300", int'(esc_val), 300);
      cmd_val = 10'd1023;
      cyc(1);
      chk("clamp_1000", int'(esc_val), 1000);
      cmd_val = 10'd7;
      cyc(1);
      chk("noslew_7", int'(esc_val), 7);
`endif

      cmd_vld = 1'b0;
      n = 0;
      while (!fault && n < 20000) begin
         cyc(1);
         n++;
      end
      chk("timeout_window", (n > 4000 && n <= 6000) ? 1 : 0, 1);
      chk("fs_fault", int'(fault), 1);
      chk("fs_esc", int'(esc_val), 0);
      chk("fs_rdy", int'(cmd_rdy), 0);
      arm_req = 1'b1;
      cyc(1);
      arm_req = 1'b0;
      cyc(3);
      chk("fs_ignores_arm", int'({fault, armed}), 2);
      disarm = 1'b1;
      cyc(1);
      disarm = 1'b0;
      chk("fs_disarm", int'(fault), 0);

      // abort arming with reset, then a fresh full arming period is required
      cmd_vld = 1'b1;
      cmd_val = '0;
      while (tmr) cyc(1);
      arm_req = 1'b1;
      cyc(1);
      arm_req = 1'b0;
      cyc(3000);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(2);
      do_arm("rearm");

      disarm  = 1'b1;
      arm_req = 1'b1;
      cmd_val = 10'd500;
      cyc(1);
      disarm  = 1'b0;
      arm_req = 1'b0;
      cmd_vld = 1'b0;
      chk("prio_state", int'({cmd_rdy, armed, fault}), 0);
      chk("prio_esc", int'(esc_val), 0);
      cyc(4);
      chk("prio_no_arm", int'(armed), 0);
      do_arm("arm_after_prio");
      chk("target_zero", int'(esc_val), 0);

      cmd_val = 10'd500;
`ifdef ESC_SEQ_SLEW_EN
      collect(2);
      chk("pre_rst_esc", int'(esc_val), 8);
`else
      cyc(1);
      chk("pre_rst_esc", int'(esc_val), 500);
`endif
      rst = 1'b1;
      #1;
      chk("async_rst_esc", int'(esc_val), 0);
      chk("async_rst_state", int'({cmd_rdy, armed, fault}), 0);
      cyc(2);
      rst = 1'b0;
      cmd_vld = 1'b0;
      cyc(3);
      chk("post_rst_armed", int'(armed), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/esc_sequencer.md
ESC_SEQUENCER -- requirements
Module: esc_sequencer

Interface
REQ-001 SHALL have parameter VAL_BITS, default 10, command/output width.
REQ-002 SHALL have parameter MAX_VAL, default 1000, command saturation ceiling.
REQ-003 SHALL have parameter ARM_MS, default 3000, zero-throttle hold before arming completes.
REQ-004 SHALL have parameter TIMEOUT_MS, default 100, command-loss window while armed.
REQ-005 SHALL have parameter RAMP_STEP, default 4, maximum esc_val change per ms.
REQ-006 SHALL have port clk, input, 1, single system clock.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-008 SHALL have port tmr_1Mhz, input, 1, one-clk-wide pulse every 1 us.
REQ-009 SHALL have port arm_req, input, 1, arming request pulse.
REQ-010 SHALL have port disarm, input, 1, disarm request (level or pulse).
REQ-011 SHALL have port cmd_val, input, VAL_BITS, requested throttle.
REQ-012 SHALL have port cmd_vld, input, 1, cmd_val valid.
REQ-013 SHALL have port cmd_rdy, output, 1, command accepted when cmd_vld & cmd_rdy.
REQ-014 SHALL have port esc_val, output, VAL_BITS, throttle value driven to esc.val.
REQ-015 SHALL have port armed, output, 1, high only in ARMED.
REQ-016 SHALL have port fault, output, 1, high only in FAILSAFE.

Function
REQ-017 SHALL implement states DISARMED, ARMING, ARMED, FAILSAFE.
REQ-018 SHALL derive a ms tick by counting 1000 tmr_1Mhz pulses; the ms prescaler SHALL clear on every state change.
REQ-019 DISARMED -> ARMING on arm_req; arm_req in any other state SHALL be ignored.
REQ-020 ARMING SHALL hold esc_val=0 and go to ARMED after ARM_MS ms ticks.
REQ-021 ARMED SHALL assert cmd_rdy; cmd_rdy SHALL be 0 in all other states and unaccepted commands dropped.
REQ-022 An accepted command SHALL load target = min(cmd_val, MAX_VAL) on the accepting clock edge.
REQ-023 Each accept SHALL clear the timeout counter; TIMEOUT_MS ms ticks without an accept SHALL move ARMED -> FAILSAFE.
REQ-024 Timeout counter SHALL start from zero on entry to ARMED.
REQ-025 FAILSAFE SHALL force esc_val=0 on the entry edge and leave only via disarm to DISARMED.
REQ-026 disarm SHALL move any state to DISARMED next clk, overriding arm_req, cmd accept and timeout in the same cycle.
REQ-027 esc_val SHALL be 0 whenever state is not ARMED; target SHALL clear to 0 on leaving ARMED.
REQ-028 Accept and timeout expiry in the same cycle: accept SHALL win, no FAILSAFE.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 rst SHALL asynchronously force DISARMED, esc_val=0, target=0, all counters=0, cmd_rdy=0, armed=0, fault=0.
REQ-031 rst asserted mid-ramp or mid-arming SHALL abort with no residual state; re-arm requires full ARM_MS.

Configuration
REQ-032 Macro ESC_SEQ_SLEW_EN SHALL select the slew limiter.
REQ-033 With ESC_SEQ_SLEW_EN defined, in ARMED esc_val SHALL move toward target by min(RAMP_STEP, |target-esc_val|) on each ms tick, never overshooting or wrapping.
REQ-034 Without ESC_SEQ_SLEW_EN, esc_val SHALL equal target one clk after accept; RAMP_STEP unused.

Verification
REQ-035 Reset: rst pulse mid-ARMED with esc_val=500 -> esc_val=0, armed=0, state DISARMED immediately.
REQ-036 Arming (ARM_MS=2): arm_req -> armed rises after exactly 2000 tmr_1Mhz pulses; cmd_vld during ARMING -> cmd_rdy=0, esc_val stays 0.
REQ-037 Slew (EN, RAMP_STEP=4): cmd_val=20 accepted from 0 -> esc_val 4,8,12,16,20 on successive ms ticks, then holds 20; cmd_val=1023 -> target clamps to 1000.
REQ-038 No slew (macro off): cmd_val=300 accepted -> esc_val=300 next clk.
REQ-039 Timeout (TIMEOUT_MS=3): no cmd for 3 ms -> fault=1, esc_val=0, cmd_rdy=0; arm_req ignored; disarm -> DISARMED, fault=0.
REQ-040 Priority: disarm, arm_req and accepted cmd in same cycle while ARMED -> DISARMED, esc_val=0, target unchanged at 0.
